// File: rtl/alu_req_sequencer.sv
// Synthesizable initiator for the combinational ALU: accepts requests, drives the ALU
// from registers, captures result/flags after a settle interval into a response FIFO.
module alu_req_sequencer #(
  parameter int unsigned RESP_DEPTH    = 4,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned TAG_W         = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_instr,
  input  logic [31:0]       req_rega,
  input  logic [31:0]       req_regb,
  input  logic [TAG_W-1:0]  req_tag,
  output logic [31:0]       alu_instruction,
  output logic [31:0]       alu_rega,
  output logic [31:0]       alu_regb,
  input  logic [31:0]       alu_result,
  input  logic [2:0]        alu_flags,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_result,
  output logic [2:0]        rsp_flags,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              busy,
  output logic [15:0]       txn_count,
  output logic [15:0]       ovf_count
);

  localparam int unsigned PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef struct packed {
    logic [31:0]      result;
    logic [2:0]       flags;
    logic [TAG_W-1:0] tag;
  } rsp_t;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [SET_W-1:0] settle_cnt;
  logic [SET_W-1:0] settle_cnt_next;
  logic             accept;
  logic             capture;
  logic             pop;
  logic             req_ready_next;
  logic             busy_next;
  logic [TAG_W-1:0] tag_q;

  rsp_t             mem [RESP_DEPTH];
  rsp_t             head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] count_next;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
    end else begin
      state      <= state_next;
      settle_cnt <= settle_cnt_next;
    end
  end

  // Next-state: accept in IDLE, count down the settle interval, capture on zero
  always_comb begin
    state_next      = state;
    settle_cnt_next = settle_cnt;
    accept          = 1'b0;
    capture         = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          accept          = 1'b1;
          state_next      = SETTLE;
          settle_cnt_next = SET_W'(SETTLE_CYCLES - 1);
        end
      end
      SETTLE: begin
        if (settle_cnt == '0) begin
          capture    = 1'b1;
          state_next = IDLE;
        end else begin
          settle_cnt_next = settle_cnt - SET_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode: next FIFO occupancy and the registered handshake/status flags
  always_comb begin
    pop            = rsp_valid && rsp_ready;
    count_next     = fifo_count;
    if (capture && !pop) begin
      count_next = fifo_count + CNT_W'(1);
    end else if (!capture && pop) begin
      count_next = fifo_count - CNT_W'(1);
    end
    req_ready_next = (state_next == IDLE) && (count_next < CNT_W'(RESP_DEPTH));
    busy_next      = (state_next != IDLE);
  end

  // ALU drive registers, tag and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_instruction <= '0;
      alu_rega        <= '0;
      alu_regb        <= '0;
      tag_q           <= '0;
      req_ready       <= 1'b0;
      busy            <= 1'b0;
    end else begin
      if (accept) begin
        alu_instruction <= req_instr;
        alu_rega        <= req_rega;
        alu_regb        <= req_regb;
        tag_q           <= req_tag;
      end
      req_ready <= req_ready_next;
      busy      <= busy_next;
    end
  end

  // Statistics: txn wraps, overflow count saturates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_count <= '0;
      ovf_count <= '0;
    end else if (capture) begin
      txn_count <= txn_count + 16'd1;
      if (alu_flags[0] && (ovf_count != 16'hFFFF)) begin
        ovf_count <= ovf_count + 16'd1;
      end
    end
  end

  // Response FIFO; storage is cleared so the head reads zero after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int unsigned i = 0; i < RESP_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (capture) begin
        mem[wr_ptr] <= '{result: alu_result, flags: alu_flags, tag: tag_q};
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      fifo_count <= count_next;
    end
  end

  assign head       = mem[rd_ptr];
  assign rsp_valid  = (fifo_count != '0);
  assign rsp_result = head.result;
  assign rsp_flags  = head.flags;
  assign rsp_tag    = head.tag;

endmodule

// File: tb/tb_alu_req_sequencer.sv
// Bench for alu_req_sequencer: behavioural ALU stand-in, response scoreboard,
// vector table plus hand-written latency, backpressure and reset sequences.
module tb_alu_req_sequencer;

  localparam logic [31:0] ADD  = 32'h00014020;

  logic        clk;
  logic        rst_n;

  logic        req_valid, req_ready, rsp_valid, rsp_ready, busy;
  logic [31:0] req_instr, req_rega, req_regb;
  logic [3:0]  req_tag, rsp_tag;
  logic [31:0] alu_instruction, alu_rega, alu_regb, alu_result, rsp_result;
  logic [2:0]  alu_flags, rsp_flags;
  logic [15:0] txn_count, ovf_count;

  logic        req_valid3, req_ready3, rsp_valid3, rsp_ready3, busy3;
  logic [31:0] req_instr3, req_rega3, req_regb3;
  logic [3:0]  req_tag3, rsp_tag3;
  logic [31:0] alu_instruction3, alu_rega3, alu_regb3, alu_result3, rsp_result3;
  logic [2:0]  alu_flags3, rsp_flags3;
  logic [15:0] txn_count3, ovf_count3;

  logic        ovr_en;
  logic [31:0] ovr_result;

  typedef struct packed {
    logic [31:0] result;
    logic [2:0]  flags;
    logic [3:0]  tag;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic [2:0]  flags;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vt[6];
  int   errors = 0;
  int   checks = 0;

  alu_req_sequencer #(.RESP_DEPTH(4), .SETTLE_CYCLES(1), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_instr(req_instr),
    .req_rega(req_rega), .req_regb(req_regb), .req_tag(req_tag),
    .alu_instruction(alu_instruction), .alu_rega(alu_rega), .alu_regb(alu_regb),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_tag(rsp_tag),
    .busy(busy), .txn_count(txn_count), .ovf_count(ovf_count)
  );

  alu_req_sequencer #(.RESP_DEPTH(4), .SETTLE_CYCLES(3), .TAG_W(4)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_instr(req_instr3),
    .req_rega(req_rega3), .req_regb(req_regb3), .req_tag(req_tag3),
    .alu_instruction(alu_instruction3), .alu_rega(alu_rega3), .alu_regb(alu_regb3),
    .alu_result(alu_result3), .alu_flags(alu_flags3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_result(rsp_result3),
    .rsp_flags(rsp_flags3), .rsp_tag(rsp_tag3),
    .busy(busy3), .txn_count(txn_count3), .ovf_count(ovf_count3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // MIPS add/addu/addi/addiu stand-in; anything else returns a fixed marker pattern
  function automatic logic [34:0] alu_model(input logic [31:0] instr, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] r;
    logic [31:0] imm;
    logic        ovf;
    ovf = 1'b0;
    imm = {{16{instr[15]}}, instr[15:0]};
    if (instr[31:26] == 6'h00 && (instr[5:0] == 6'h20 || instr[5:0] == 6'h21)) begin
      r = a + b;
      if (instr[5:0] == 6'h20) ovf = (a[31] == b[31]) && (r[31] != a[31]);
    end else if (instr[31:26] == 6'h08 || instr[31:26] == 6'h09) begin
      r = b + imm;
      if (instr[31:26] == 6'h08) ovf = (b[31] == imm[31]) && (r[31] != b[31]);
    end else begin
      return {3'b110, 32'hDEADBEEF};
    end
    return {r == 32'd0, r[31], ovf, r};
  endfunction

  always_comb {alu_flags, alu_result} = alu_model(alu_instruction, alu_rega, alu_regb);

  always_comb begin
    {alu_flags3, alu_result3} = alu_model(alu_instruction3, alu_rega3, alu_regb3);
    if (ovr_en) alu_result3 = ovr_result;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every response the consumer takes must match the oldest expectation
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid && rsp_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: got tag %0d result %h, expected no response",
                   rsp_tag, rsp_result);
        end else begin
          mon_e = sb.pop_front();
          if ({rsp_result, rsp_flags, rsp_tag} !== mon_e) begin
            errors++;
            $display("FAIL rsp_data: got result=%h flags=%b tag=%0d, expected result=%h flags=%b tag=%0d",
                     rsp_result, rsp_flags, rsp_tag, mon_e.result, mon_e.flags, mon_e.tag);
          end
        end
      end
    end
  end

  // Offer a request and return #1 after the accepting edge
  task automatic send(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] tag, input exp_t e);
    int n;
    n = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_instr = instr; req_rega = a; req_regb = b; req_tag = tag;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!req_ready) begin
      errors++;
      $display("FAIL accept_timeout: got req_ready=0 for tag %0d, expected 1", tag);
      req_valid = 1'b0;
    end else begin
      sb.push_back(e);
      @(posedge clk); #1;
      req_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d outstanding, expected 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vt[0] = '{ADD,          32'hFFFFFFF6, 32'd10,       32'h00000000, 3'b100};
    vt[1] = '{32'h2020FF9C, 32'd0,        32'd19,       32'hFFFFFFAF, 3'b010};
    vt[2] = '{ADD,          32'h7FFFFFF8, 32'h7FFFFFF9, 32'hFFFFFFF1, 3'b011};
    vt[3] = '{32'h00014021, 32'h7FFFFFF8, 32'h7FFFFFF9, 32'hFFFFFFF1, 3'b010};
    vt[4] = '{32'h2420FFFF, 32'd0,        32'd1,        32'h00000000, 3'b100};
    vt[5] = '{32'hFC000000, 32'd1,        32'd2,        32'hDEADBEEF, 3'b110};

    req_valid = 0; req_instr = 0; req_rega = 0; req_regb = 0; req_tag = 0; rsp_ready = 1;
    req_valid3 = 0; req_instr3 = 0; req_rega3 = 0; req_regb3 = 0; req_tag3 = 0; rsp_ready3 = 0;
    ovr_en = 0; ovr_result = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_txn", txn_count, 0);
    chk("rst_ovf", ovf_count, 0);
    repeat (3) @(posedge clk);
    #1 chk("rst_hold_req_ready", req_ready, 0);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("rel_req_ready_before_edge", req_ready, 0);
    @(posedge clk); #1;
    chk("rel_req_ready", req_ready, 1);
    chk("rel_req_ready3", req_ready3, 1);

    // basic add with latency observation
    send(ADD, 32'd4, 32'd5, 4'd0, exp_t'({32'd9, 3'b000, 4'd0}));
    chk("basic_busy_after_accept", busy, 1);
    chk("basic_rsp_valid_early", rsp_valid, 0);
    chk("basic_req_ready_settle", req_ready, 0);
    chk("basic_alu_instr", alu_instruction, ADD);
    chk("basic_alu_rega", alu_rega, 32'd4);
    @(posedge clk); #1;
    chk("basic_rsp_valid", rsp_valid, 1);
    chk("basic_rsp_result", rsp_result, 32'd9);
    chk("basic_rsp_flags", rsp_flags, 0);
    chk("basic_txn", txn_count, 1);
    chk("basic_busy_done", busy, 0);

    for (int i = 0; i < 6; i++) begin
      send(vt[i].instr, vt[i].a, vt[i].b, 4'(i + 1),
           exp_t'({vt[i].result, vt[i].flags, 4'(i + 1)}));
    end
    wait_drain();
    chk("table_txn", txn_count, 7);
    chk("table_ovf", ovf_count, 1);
    chk("table_alu_hold", alu_instruction, 32'hFC000000);

    // backpressure: four fill the FIFO, the fifth waits for one pop
    rsp_ready = 0;
    for (int t = 0; t < 4; t++) begin
      send(ADD, 32'(t * 3), 32'd7, 4'(t), exp_t'({32'(t * 3 + 7), 3'b000, 4'(t)}));
    end
    @(posedge clk); #1;
    chk("bp_full_req_ready", req_ready, 0);
    chk("bp_full_rsp_valid", rsp_valid, 1);
    chk("bp_full_head_tag", rsp_tag, 0);
    req_valid = 1; req_instr = ADD; req_rega = 32'd12; req_regb = 32'd7; req_tag = 4'd4;
    repeat (3) begin
      @(posedge clk); #1;
      chk("bp_blocked_req_ready", req_ready, 0);
      chk("bp_blocked_busy", busy, 0);
    end
    chk("bp_inputs_ignored", alu_rega, 32'd9);
    sb.push_back(exp_t'({32'd19, 3'b000, 4'd4}));
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    chk("bp_req_ready_after_pop", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 0;
    chk("bp_fifth_accepted", busy, 1);
    rsp_ready = 1;
    wait_drain();
    chk("bp_txn", txn_count, 12);

    // settle interval of three on the second instance; result changes after E2
    @(posedge clk); #1;
    req_valid3 = 1; req_instr3 = ADD; req_rega3 = 32'd1; req_regb3 = 32'd2; req_tag3 = 4'd5;
    chk("s3_req_ready", req_ready3, 1);
    @(posedge clk); #1;
    req_valid3 = 0;
    chk("s3_busy_e0", busy3, 1);
    @(posedge clk); #1;
    chk("s3_busy_e1", busy3, 1);
    chk("s3_rsp_valid_e1", rsp_valid3, 0);
    @(posedge clk); #1;
    ovr_result = 32'h12345678; ovr_en = 1;
    chk("s3_busy_e2", busy3, 1);
    chk("s3_rsp_valid_e2", rsp_valid3, 0);
    @(posedge clk); #1;
    chk("s3_busy_e3", busy3, 0);
    chk("s3_rsp_valid_e3", rsp_valid3, 1);
    chk("s3_rsp_result", rsp_result3, 32'h12345678);
    chk("s3_rsp_tag", rsp_tag3, 5);
    chk("s3_txn", txn_count3, 1);
    chk("s3_req_ready_e3", req_ready3, 1);
    rsp_ready3 = 1;
    @(posedge clk); #1;
    rsp_ready3 = 0; ovr_en = 0;
    chk("s3_popped", rsp_valid3, 0);

    // reset while SETTLE with two responses queued
    rsp_ready = 0;
    send(ADD, 32'd1, 32'd1, 4'd6, exp_t'({32'd2, 3'b000, 4'd6}));
    send(ADD, 32'd2, 32'd2, 4'd7, exp_t'({32'd4, 3'b000, 4'd7}));
    send(ADD, 32'd3, 32'd3, 4'd8, exp_t'({32'd6, 3'b000, 4'd8}));
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("mid_rsp_valid", rsp_valid, 0);
    chk("mid_busy_rst", busy, 0);
    chk("mid_txn", txn_count, 0);
    chk("mid_ovf", ovf_count, 0);
    chk("mid_alu_instr", alu_instruction, 0);
    chk("mid_alu_rega", alu_rega, 0);
    chk("mid_alu_regb", alu_regb, 0);
    chk("mid_req_ready", req_ready, 0);
    chk("mid_rsp_result", rsp_result, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_rel_req_ready", req_ready, 1);
    rsp_ready = 1;
    send(ADD, 32'd4, 32'd5, 4'd9, exp_t'({32'd9, 3'b000, 4'd9}));
    wait_drain();
    chk("mid_fresh_txn", txn_count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
